// File: rtl/alarm_ring_pkg.sv
// Shared definitions for the alarm ring block: time field width and FSM state encodings.
package alarm_ring_pkg;

    localparam int unsigned TIME_W = 6;
    localparam int unsigned ST_W   = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_e;

endpackage

// File: rtl/alarm_ring_tick_cnt.sv
// Seconds counter with synchronous clear, increment on tick and a terminal flag
// that fires on the tick that would take the count to limit.
module tick_cnt #(
    parameter int unsigned CNT_W = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             tick,
    input  logic [CNT_W-1:0] limit,
    output logic             done_c
);

    logic [CNT_W-1:0] count;

    assign done_c = tick & (count == (limit - CNT_W'(1)));

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alarm_ring.sv
// Alarm comparator, edge detect and ring FSM driving the buzzer pin.
// Optional snooze support is compiled in with `define ALARM_SNOOZE_EN.
module alarm_ring
    import alarm_ring_pkg::*;
#(
    parameter int unsigned RING_SECS   = 60,
`ifdef ALARM_SNOOZE_EN
    parameter int unsigned SNOOZE_SECS = 300,
    parameter int unsigned MAX_SNOOZE  = 3,
`endif
    parameter int unsigned CNT_W       = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tick_1hz,
    input  logic              alarm_en,
    input  logic              stop_key,
`ifdef ALARM_SNOOZE_EN
    input  logic              snooze_key,
`endif
    input  logic [TIME_W-1:0] cur_hour,
    input  logic [TIME_W-1:0] cur_minute,
    input  logic [TIME_W-1:0] cur_second,
    input  logic [TIME_W-1:0] alm_hour,
    input  logic [TIME_W-1:0] alm_minute,
    input  logic [TIME_W-1:0] alm_second,
    output logic              ringing,
    output logic              buzzer
);

`ifdef ALARM_SNOOZE_EN
    localparam int unsigned SNZ_W = $clog2(MAX_SNOOZE + 1);
    logic [SNZ_W-1:0] snz_cnt;
    logic [SNZ_W-1:0] snz_next;
`endif

    state_e           state;
    state_e           next_state;
    logic             phase;
    logic             next_phase;
    logic             match;
    logic             match_q;
    logic             trigger;
    logic             cnt_clear;
    logic             cnt_done;
    logic [CNT_W-1:0] cnt_limit;

    assign match   = alarm_en & (cur_hour == alm_hour) & (cur_minute == alm_minute)
                   & (cur_second == alm_second);
    assign trigger = match & ~match_q;

    // Counter is held clear in IDLE and restarts on every state change.
    assign cnt_clear = (state == ST_IDLE) | (next_state != state);

`ifdef ALARM_SNOOZE_EN
    assign cnt_limit = (state == ST_SNOOZE) ? CNT_W'(SNOOZE_SECS) : CNT_W'(RING_SECS);
`else
    assign cnt_limit = CNT_W'(RING_SECS);
`endif

    tick_cnt #(
        .CNT_W (CNT_W)
    ) u_tick_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clear),
        .tick   (tick_1hz),
        .limit  (cnt_limit),
        .done_c (cnt_done)
    );

    always_comb begin
        next_state = state;
        next_phase = phase;
`ifdef ALARM_SNOOZE_EN
        snz_next   = snz_cnt;
`endif
        case (state)
            ST_IDLE: begin
                if (trigger) begin
                    next_state = ST_RING;
                    next_phase = 1'b1;
                end
            end
            ST_RING: begin
                if (stop_key) begin
                    next_state = ST_IDLE;
`ifdef ALARM_SNOOZE_EN
                end else if (snooze_key && (snz_cnt < SNZ_W'(MAX_SNOOZE))) begin
                    next_state = ST_SNOOZE;
                    snz_next   = snz_cnt + SNZ_W'(1);
`endif
                end else if (cnt_done) begin
                    next_state = ST_IDLE;
                end else if (tick_1hz) begin
                    next_phase = ~phase;
                end
            end
`ifdef ALARM_SNOOZE_EN
            ST_SNOOZE: begin
                if (stop_key) begin
                    next_state = ST_IDLE;
                end else if (cnt_done) begin
                    next_state = ST_RING;
                    next_phase = 1'b1;
                end
            end
`endif
            default: next_state = ST_IDLE;
        endcase
        // Disarming wins over every other event.
        if (!alarm_en) begin
            next_state = ST_IDLE;
        end
`ifdef ALARM_SNOOZE_EN
        if (next_state == ST_IDLE) begin
            snz_next = '0;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            phase   <= 1'b0;
            match_q <= 1'b0;
            ringing <= 1'b0;
            buzzer  <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snz_cnt <= '0;
`endif
        end else begin
            state   <= next_state;
            phase   <= next_phase;
            match_q <= match;
            ringing <= (next_state == ST_RING);
            buzzer  <= (next_state == ST_RING) & next_phase;
`ifdef ALARM_SNOOZE_EN
            snz_cnt <= snz_next;
`endif
        end
    end

endmodule

// File: tb/tb_alarm_ring.sv
// Directed bench for alarm_ring: a 60 s ring instance and a 3 s ring instance on shared inputs.
module tb_alarm_ring;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1hz;
    logic       alarm_en;
    logic       stop_key;
`ifdef ALARM_SNOOZE_EN
    logic       snooze_key;
`endif
    logic [5:0] cur_hour, cur_minute, cur_second;
    logic [5:0] alm_hour, alm_minute, alm_second;
    logic       ringing, buzzer;
    logic       ringing3, buzzer3;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    alarm_ring #(
        .RING_SECS   (60),
`ifdef ALARM_SNOOZE_EN
        .SNOOZE_SECS (5),
        .MAX_SNOOZE  (3),
`endif
        .CNT_W       (9)
    ) u_dut (
        .clock      (clk),
        .reset      (reset),
        .tick_1hz   (tick_1hz),
        .alarm_en   (alarm_en),
        .stop_key   (stop_key),
`ifdef ALARM_SNOOZE_EN
        .snooze_key (snooze_key),
`endif
        .cur_hour   (cur_hour),
        .cur_minute (cur_minute),
        .cur_second (cur_second),
        .alm_hour   (alm_hour),
        .alm_minute (alm_minute),
        .alm_second (alm_second),
        .ringing    (ringing),
        .buzzer     (buzzer)
    );

    alarm_ring #(
        .RING_SECS (3),
        .CNT_W     (9)
    ) u_dut3 (
        .clock      (clk),
        .reset      (reset),
        .tick_1hz   (tick_1hz),
        .alarm_en   (alarm_en),
        .stop_key   (stop_key),
`ifdef ALARM_SNOOZE_EN
        .snooze_key (snooze_key),
`endif
        .cur_hour   (cur_hour),
        .cur_minute (cur_minute),
        .cur_second (cur_second),
        .alm_hour   (alm_hour),
        .alm_minute (alm_minute),
        .alm_second (alm_second),
        .ringing    (ringing3),
        .buzzer     (buzzer3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
    endtask

    task automatic set_cur(input int h, input int m, input int s);
        cur_hour   = 6'(h);
        cur_minute = 6'(m);
        cur_second = 6'(s);
    endtask

    // Fresh alarm event: time steps 07:29:59 -> 07:30:00.
    task automatic arm_ring();
        set_cur(7, 29, 59);
        step();
        set_cur(7, 30, 0);
        step();
    endtask

    initial begin
        reset    = 1'b1;
        tick_1hz = 1'b0;
        alarm_en = 1'b1;
        stop_key = 1'b0;
`ifdef ALARM_SNOOZE_EN
        snooze_key = 1'b0;
`endif
        alm_hour   = 6'd7;
        alm_minute = 6'd30;
        alm_second = 6'd0;
        set_cur(7, 29, 58);
        step();
        step();
        check("reset_ringing", 32'(ringing), 0);
        check("reset_buzzer", 32'(buzzer), 0);
        reset = 1'b0;

        // 1: full 60 s ring, no retrigger while time still matches
        set_cur(7, 29, 59);
        step();
        check("pre_match_ringing", 32'(ringing), 0);
        set_cur(7, 30, 0);
        step();
        check("t1_ring_start", 32'(ringing), 1);
        check("t1_buzz_start", 32'(buzzer), 1);
        for (int i = 1; i <= 60; i++) begin
            pulse_tick();
            if (i < 60) begin
                check($sformatf("t1_ring_tick%0d", i), 32'(ringing), 1);
                check($sformatf("t1_buzz_tick%0d", i), 32'(buzzer), 32'((i % 2) == 0));
            end else begin
                check("t1_timeout_ringing", 32'(ringing), 0);
                check("t1_timeout_buzzer", 32'(buzzer), 0);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step();
            check("t1_no_retrigger", 32'(ringing), 0);
        end
        pulse_tick();
        check("t1_no_retrigger_tick", 32'(ringing), 0);

        // 2: stop key on the 5th tick
        arm_ring();
        check("t2_ring_start", 32'(ringing), 1);
        for (int i = 0; i < 4; i++) pulse_tick();
        check("t2_ring_tick4", 32'(ringing), 1);
        check("t2_buzz_tick4", 32'(buzzer), 1);
        stop_key = 1'b1;
        pulse_tick();
        stop_key = 1'b0;
        check("t2_stop_ringing", 32'(ringing), 0);
        check("t2_stop_buzzer", 32'(buzzer), 0);
        set_cur(7, 30, 1);
        step();
        check("t2_no_retrigger", 32'(ringing), 0);

        // 3: disarm during ring, then disarmed at match time
        arm_ring();
        check("t3_ring_start", 32'(ringing), 1);
        pulse_tick();
        pulse_tick();
        alarm_en = 1'b0;
        step();
        check("t3_disarm_ringing", 32'(ringing), 0);
        check("t3_disarm_buzzer", 32'(buzzer), 0);
        arm_ring();
        check("t3_disarmed_match", 32'(ringing), 0);
        step();
        check("t3_disarmed_hold", 32'(ringing), 0);
        set_cur(7, 29, 59);
        step();
        alarm_en = 1'b1;
        step();

        // 4: 3 s ring; stop coinciding with terminal tick; natural timeout; reset mid-ring
        arm_ring();
        check("t4_ring3_start", 32'(ringing3), 1);
        pulse_tick();
        check("t4_buzz3_tick1", 32'(buzzer3), 0);
        pulse_tick();
        check("t4_buzz3_tick2", 32'(buzzer3), 1);
        stop_key = 1'b1;
        pulse_tick();
        stop_key = 1'b0;
        check("t4_stop_term_ringing3", 32'(ringing3), 0);
        check("t4_stop_term_buzzer3", 32'(buzzer3), 0);
        check("t4_stop_ringing60", 32'(ringing), 0);
        step();
        check("t4_stop_term_hold", 32'(ringing3), 0);
        arm_ring();
        pulse_tick();
        pulse_tick();
        check("t4_ring3_before_to", 32'(ringing3), 1);
        pulse_tick();
        check("t4_ring3_timeout", 32'(ringing3), 0);
        check("t4_ring60_still", 32'(ringing), 1);
        reset = 1'b1;
        step();
        check("t4_reset_ringing", 32'(ringing), 0);
        check("t4_reset_buzzer", 32'(buzzer), 0);
        reset = 1'b0;
        step();
        check("t4_match_at_release", 32'(ringing), 1);
        stop_key = 1'b1;
        step();
        stop_key = 1'b0;
        check("t4_release_stop", 32'(ringing), 0);

`ifdef ALARM_SNOOZE_EN
        // 5: snooze three times, fourth snooze ignored
        arm_ring();
        check("t5_ring_start", 32'(ringing), 1);
        for (int n = 1; n <= 3; n++) begin
            snooze_key = 1'b1;
            step();
            snooze_key = 1'b0;
            check($sformatf("t5_snooze%0d_ringing", n), 32'(ringing), 0);
            check($sformatf("t5_snooze%0d_buzzer", n), 32'(buzzer), 0);
            for (int i = 0; i < 4; i++) pulse_tick();
            check($sformatf("t5_snooze%0d_silent", n), 32'(ringing), 0);
            pulse_tick();
            check($sformatf("t5_snooze%0d_resume", n), 32'(ringing), 1);
            check($sformatf("t5_snooze%0d_buzz", n), 32'(buzzer), 1);
        end
        snooze_key = 1'b1;
        step();
        snooze_key = 1'b0;
        check("t5_snooze4_ignored", 32'(ringing), 1);
        stop_key = 1'b1;
        step();
        stop_key = 1'b0;
        check("t5_stop", 32'(ringing), 0);
`endif

        // 6: keys in IDLE are ignored
        set_cur(8, 0, 0);
        step();
        stop_key = 1'b1;
        step();
        stop_key = 1'b0;
        check("t6_stop_idle_ringing", 32'(ringing), 0);
        check("t6_stop_idle_buzzer", 32'(buzzer), 0);
`ifdef ALARM_SNOOZE_EN
        snooze_key = 1'b1;
        step();
        snooze_key = 1'b0;
        check("t6_snooze_idle_ringing", 32'(ringing), 0);
`endif
        pulse_tick();
        check("t6_tick_idle_ringing", 32'(ringing), 0);
        check("t6_tick_idle_buzzer3", 32'(buzzer3), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
